// File: rtl/axi_buffer_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_buffer_wr_arbiter
//
// Round-robin arbiter that shares the single write port of an axi_buffer
// FIFO between NUM_REQ producers. One producer owns the port at a time; the
// ownership (a burst) ends on a word marked last, after MAX_BURST words, or
// as soon as the owner drops valid. At least one idle cycle separates two
// bursts because arbitration only happens in the idle state.
//
// Optional feature (compile-time macro AXI_BUFFER_ARB_SRCID_EN):
//   defined   -> o_fifo_data = {source index, payload}, DATA_WIDTH+IDW bits
//   undefined -> o_fifo_data = payload, DATA_WIDTH bits
//
// Ports
//   clk                  rising-edge clock
//   reset                synchronous, active-high
//   i_req_valid          per-producer word valid
//   i_req_data           producer k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_req_last           per-producer last-word marker
//   o_req_ready          per-producer accept, at most one bit high
//   o_fifo_data          word presented to the FIFO write port
//   o_fifo_write_enable  FIFO write strobe (never high while full)
//   i_fifo_full          FIFO full flag
//   i_fifo_data_count    FIFO occupancy, status only (not used for control)
//   o_grant              one-hot current owner, 0 when idle
//   o_busy               high while a burst is in progress
// ---------------------------------------------------------------------------
module axi_buffer_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]              i_req_last,
    output logic [NUM_REQ-1:0]              o_req_ready,
`ifdef AXI_BUFFER_ARB_SRCID_EN
    output logic [DATA_WIDTH+$clog2(NUM_REQ)-1:0] o_fifo_data,
`else
    output logic [DATA_WIDTH-1:0]           o_fifo_data,
`endif
    output logic                            o_fifo_write_enable,
    input  logic                            i_fifo_full,
    input  logic [$clog2(DEPTH):0]          i_fifo_data_count,
    output logic [NUM_REQ-1:0]              o_grant,
    output logic                            o_busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    localparam logic [CW-1:0]      BURST_MAX = CW'(MAX_BURST);
    localparam logic [IDW-1:0]     LAST_IDX  = IDW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    // Burst counter increment that sticks at MAX_BURST.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v >= BURST_MAX) ? v : v + 1'b1;
    endfunction

    logic                  state;
    logic [IDW-1:0]        gnt_idx;
    logic [IDW-1:0]        last_gnt;
    logic [CW-1:0]         burst_cnt;

    logic                  in_burst;
    logic                  g_valid;
    logic                  g_last;
    logic                  xfer;
    logic                  burst_end;
    logic [CW-1:0]         cnt_next;
    logic [DATA_WIDTH-1:0] payload;

    logic                  found;
    logic [IDW-1:0]        next_idx;

    // Occupancy is informational only; reduce it so it is not left dangling.
    logic                  unused_data_count;
    assign unused_data_count = ^i_fifo_data_count;

    // Round-robin scan starting one past the previous owner.
    always_comb begin
        int cand;
        cand     = 0;
        found    = 1'b0;
        next_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_gnt) + i) % NUM_REQ;
            if (!found && i_req_valid[IDW'(cand)]) begin
                found    = 1'b1;
                next_idx = IDW'(cand);
            end
        end
    end

    assign in_burst = (state == ST_BURST);
    assign g_valid  = i_req_valid[gnt_idx];
    assign g_last   = i_req_last[gnt_idx];
    assign payload  = i_req_data[int'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];

    // Ready only reflects full; a word moves when the owner is also valid.
    assign xfer     = in_burst & g_valid & ~i_fifo_full;
    assign cnt_next = sat_inc(burst_cnt);

    // A stall (owner valid low) releases the port even while the FIFO is full.
    assign burst_end = in_burst &
                       ((xfer & g_last) |
                        (xfer & (cnt_next == BURST_MAX)) |
                        ~g_valid);

    always_comb begin
        o_req_ready = '0;
        if (in_burst && !i_fifo_full) begin
            o_req_ready[gnt_idx] = 1'b1;
        end
    end

    assign o_fifo_write_enable = xfer;
    assign o_busy              = in_burst;

`ifdef AXI_BUFFER_ARB_SRCID_EN
    assign o_fifo_data = in_burst ? {gnt_idx, payload} : '0;
`else
    assign o_fifo_data = in_burst ? payload : '0;
`endif

    // ---- arbitration / burst state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            gnt_idx   <= '0;
            last_gnt  <= LAST_IDX;
            burst_cnt <= '0;
            o_grant   <= '0;
        end else if (!in_burst) begin
            if (found && !i_fifo_full) begin
                state     <= ST_BURST;
                gnt_idx   <= next_idx;
                burst_cnt <= '0;
                o_grant   <= ONE_HOT0 << next_idx;
            end
        end else begin
            if (xfer) begin
                burst_cnt <= cnt_next;
            end
            if (burst_end) begin
                state    <= ST_IDLE;
                last_gnt <= gnt_idx;
                o_grant  <= '0;
            end
        end
    end

endmodule
